// File: rtl/stack_sequencer_pkg.sv
// Shared operand-stack encodings: stack op/status codes, core command codes and sequencer state types.
package stack_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stk_op_e;

    typedef enum logic [1:0] {
        ST_NONE      = 2'd0,
        ST_EMPTY     = 2'd1,
        ST_UNDERFLOW = 2'd2,
        ST_OVERFLOW  = 2'd3
    } stk_status_e;

    typedef enum logic [2:0] {
        CMD_PUSH    = 3'd0,
        CMD_POP     = 3'd1,
        CMD_REPLACE = 3'd2,
        CMD_PEEK    = 3'd3,
        CMD_CALL    = 3'd4,
        CMD_RETURN  = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } seq_state_e;

    // RETURN walks through these phases: unwind callee values, restore limit, re-push result.
    typedef enum logic [1:0] {
        PH_POPS  = 2'd0,
        PH_FRAME = 2'd1,
        PH_PUSH  = 2'd2
    } ret_phase_e;

    function automatic logic is_fault(input logic [1:0] status);
        return (status == ST_UNDERFLOW) || (status == ST_OVERFLOW);
    endfunction

endpackage

// File: rtl/stack_sequencer_frame_lifo.sv
// LIFO of saved caller underflow limits; registered top/full/empty flags.
module stack_sequencer_frame_lifo
    import stack_sequencer_pkg::*;
#(
    parameter int unsigned W      = 9,
    parameter int unsigned FRAMES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_value,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned ENTRIES = 2 ** FRAMES;
    localparam int unsigned CW      = FRAMES + 1;

    logic [W-1:0]  mem [ENTRIES];
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem   <= '{default: '0};
            count <= '0;
            top   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (push && !full) begin
            mem[count[FRAMES-1:0]] <= push_value;
            count <= count + CW'(1);
            top   <= push_value;
            full  <= (count + CW'(1)) == CW'(ENTRIES);
            empty <= 1'b0;
        end else if (pop && !empty) begin
            // New top sits two below the write pointer; garbage when the LIFO drains, masked by empty.
            count <= count - CW'(1);
            top   <= mem[FRAMES'(count - CW'(2))];
            full  <= 1'b0;
            empty <= count == CW'(1);
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Command front end for the operand stack: prechecks requests, sequences stack op pairs, tracks depth and frames.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [WIDTH-1:0] req_data,
    input  logic [DEPTH:0]   req_arg,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_status,
    output logic [1:0]       stk_op,
    output logic [WIDTH-1:0] stk_data,
    output logic [DEPTH:0]   stk_limit,
    input  logic [WIDTH-1:0] stk_tos,
    input  logic [1:0]       stk_status
);

    localparam int unsigned DW       = DEPTH + 1;
    localparam int unsigned CAPACITY = 2 ** DEPTH;

    seq_state_e       state;
    ret_phase_e       phase;
    logic [2:0]       cmd_q;
    logic             nres_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] top_q;
    logic [DW-1:0]    depth;
    logic [DW-1:0]    limit;

    logic [DW-1:0]    lifo_top;
    logic             lifo_full;
    logic             lifo_empty;
    logic             lifo_push_c;
    logic             lifo_pop_c;

    logic [DW-1:0]    avail_c;
    logic             pre_fail_c;
    logic [1:0]       pre_status_c;
    logic [DW-1:0]    depth_nx_c;
    logic [DW-1:0]    limit_nx_c;
    logic             last_c;
    logic             ok_c;

    stack_sequencer_frame_lifo #(
        .W      (DW),
        .FRAMES (FRAMES)
    ) u_frame_lifo (
        .clk        (clk),
        .reset      (reset),
        .push       (lifo_push_c),
        .pop        (lifo_pop_c),
        .push_value (limit),
        .top        (lifo_top),
        .full       (lifo_full),
        .empty      (lifo_empty)
    );

    // Accept-time prechecks; a failure answers without touching the stack.
    always_comb begin
        pre_fail_c   = 1'b0;
        pre_status_c = ST_NONE;
        avail_c      = depth - limit;
        case (req_cmd)
            CMD_PUSH: begin
                if (depth == DW'(CAPACITY)) begin
                    pre_fail_c   = 1'b1;
                    pre_status_c = ST_OVERFLOW;
                end
            end
            CMD_POP, CMD_REPLACE, CMD_PEEK: begin
                if (depth == limit) begin
                    pre_fail_c   = 1'b1;
                    pre_status_c = ST_UNDERFLOW;
                end
            end
            CMD_CALL: begin
                if (req_arg > avail_c) begin
                    pre_fail_c   = 1'b1;
                    pre_status_c = ST_UNDERFLOW;
                end else if (lifo_full) begin
                    pre_fail_c   = 1'b1;
                    pre_status_c = ST_OVERFLOW;
                end
            end
            CMD_RETURN: begin
                if (lifo_empty || (req_arg[0] && (depth == limit))) begin
                    pre_fail_c   = 1'b1;
                    pre_status_c = ST_UNDERFLOW;
                end
            end
            default: begin
                pre_fail_c   = 1'b1;
                pre_status_c = ST_UNDERFLOW;
            end
        endcase
    end

    // Shadow-state commit for the pair completing in WAIT, and frame LIFO strobes.
    always_comb begin
        depth_nx_c = depth;
        limit_nx_c = limit;
        last_c     = 1'b1;
        case (cmd_q)
            CMD_PUSH: depth_nx_c = depth + DW'(1);
            CMD_POP:  depth_nx_c = depth - DW'(1);
            CMD_CALL: limit_nx_c = stk_limit;
            CMD_RETURN: begin
                case (phase)
                    PH_POPS: begin
                        depth_nx_c = depth - DW'(1);
                        last_c     = 1'b0;
                    end
                    PH_FRAME: begin
                        limit_nx_c = stk_limit;
                        last_c     = !nres_q;
                    end
                    default: depth_nx_c = depth + DW'(1);
                endcase
            end
            default: ;
        endcase
        ok_c        = (state == S_WAIT) && !is_fault(stk_status);
        lifo_push_c = ok_c && (cmd_q == CMD_CALL);
        lifo_pop_c  = ok_c && (cmd_q == CMD_RETURN) && (phase == PH_FRAME);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= PH_POPS;
            cmd_q      <= '0;
            nres_q     <= 1'b0;
            result_q   <= '0;
            top_q      <= '0;
            depth      <= '0;
            limit      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= ST_EMPTY;
            stk_op     <= OP_NONE;
            stk_data   <= '0;
            stk_limit  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cmd_q     <= req_cmd;
                        nres_q    <= req_arg[0];
                        result_q  <= top_q;
                        if (pre_fail_c) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= pre_status_c;
                            rsp_data   <= '0;
                        end else begin
                            state <= S_ISSUE;
                            phase <= PH_POPS;
                            case (req_cmd)
                                CMD_PUSH, CMD_REPLACE: begin
                                    stk_op   <= (req_cmd == CMD_PUSH) ? OP_PUSH : OP_REPLACE;
                                    stk_data <= req_data;
                                end
                                CMD_POP:  stk_op    <= OP_POP;
                                CMD_CALL: stk_limit <= depth - req_arg;
                                CMD_RETURN: begin
                                    if (depth == limit) begin
                                        phase     <= PH_FRAME;
                                        stk_limit <= lifo_top;
                                    end else begin
                                        stk_op <= OP_POP;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    stk_op <= OP_NONE;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    top_q <= stk_tos;
                    if (is_fault(stk_status)) begin
                        stk_limit  <= limit;
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= stk_status;
                        rsp_data   <= '0;
                    end else begin
                        depth <= depth_nx_c;
                        limit <= limit_nx_c;
                        if (last_c) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= (depth_nx_c == limit_nx_c) ? ST_EMPTY : ST_NONE;
                            rsp_data   <= (cmd_q == CMD_POP)  ? result_q :
                                          (cmd_q == CMD_PEEK) ? stk_tos  : '0;
                        end else begin
                            state <= S_ISSUE;
                            if (phase == PH_POPS) begin
                                if (depth_nx_c == limit) begin
                                    phase     <= PH_FRAME;
                                    stk_limit <= lifo_top;
                                end else begin
                                    stk_op <= OP_POP;
                                end
                            end else begin
                                phase    <= PH_PUSH;
                                stk_op   <= OP_PUSH;
                                stk_data <= result_q;
                            end
                        end
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
